// File: rtl/clken_pkg.sv
// Shared types and constants for the clock-enable generator.
// Holds the lock FSM encoding and the lock-counter width helper.
package clken_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Sized to hold LOCK_CYCLES itself, not just LOCK_CYCLES-1.
    function automatic int lock_cnt_w(input int lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/clken_nco_ch.sv
// One NCO channel: phase accumulator, increment register and the
// registered ce/clk outputs derived from the accumulator carry and MSB.
module clken_nco_ch
    import clken_pkg::*;
#(
    parameter int               ACC_W    = 32,
    parameter logic [ACC_W-1:0] DEF_INCR = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic             clr_i,
    input  logic [ACC_W-1:0] incr_i,
    output logic             ce_o,
    output logic             clk_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] incr_q, incr_d;
    logic             ce_q, ce_d;
    logic             clk_q, clk_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, incr_q};
        acc_d  = acc_q;
        incr_d = incr_q;
        ce_d   = 1'b0;
        clk_d  = clk_q;
        if (en_i) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = sum[ACC_W];
            clk_d = sum[ACC_W-1];
        end
        // A new increment is only seen by the adder from the next edge on.
        if (wr_i) begin
            incr_d = incr_i;
            if (clr_i) begin
                acc_d = '0;
                ce_d  = 1'b0;
                clk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            incr_q <= DEF_INCR;
            ce_q   <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            incr_q <= incr_d;
            ce_q   <= ce_d;
            clk_q  <= clk_d;
        end
    end

    assign ce_o  = ce_q;
    assign clk_o = clk_q;

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator with a settle/lock
// indicator that restarts whenever any channel is reprogrammed.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                           NUM_CH      = 2,
    parameter int                           ACC_W       = 32,
    parameter int                           LOCK_CYCLES = 1024,
    parameter logic [NUM_CH-1:0][ACC_W-1:0] DEF_INCR    = {NUM_CH{ACC_W'(0)}}
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [ACC_W-1:0]  wr_incr,
    input  logic              wr_clr,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int         CNT_W    = lock_cnt_w(LOCK_CYCLES);
    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

    logic              wr_valid;
    lock_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              locked_q;

    // Writes to channels beyond NUM_CH vanish without touching lock.
    assign wr_valid = wr_en && ({1'b0, wr_ch} < NUM_CH_L);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clken_nco_ch #(
            .ACC_W    (ACC_W),
            .DEF_INCR (DEF_INCR[g])
        ) u_ch (
            .refclk (refclk),
            .rst    (rst),
            .en_i   (ch_en[g]),
            .wr_i   (wr_valid && (wr_ch == 3'(g))),
            .clr_i  (wr_clr),
            .incr_i (wr_incr),
            .ce_o   (ce_out[g]),
            .clk_o  (clk_out[g])
        );
    end

    // A write on the terminal-count edge takes priority and restarts settling.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else if (wr_valid) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOCKED: locked_q <= 1'b1;
                default: begin
                    state_q  <= SETTLE;
                    cnt_q    <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clken_gen.sv
// Randomized and directed bench for clken_gen (2 channels, 8-bit accumulator).
module tb_clken_gen;

    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int LC  = 16;
    localparam longint M = 256;
    localparam logic [NCH-1:0][W-1:0] DEF = {8'd0, 8'd64};

    logic           refclk = 1'b0;
    logic           rst    = 1'b1;
    logic [NCH-1:0] ch_en  = '0;
    logic           wr_en  = 1'b0;
    logic [2:0]     wr_ch  = '0;
    logic [W-1:0]   wr_incr = '0;
    logic           wr_clr = 1'b0;
    logic [NCH-1:0] ce_out, clk_out;
    logic           locked;

    clken_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (W),
        .LOCK_CYCLES (LC),
        .DEF_INCR    (DEF)
    ) dut (
        .refclk  (refclk),
        .rst     (rst),
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_incr (wr_incr),
        .wr_clr  (wr_clr),
        .ce_out  (ce_out),
        .clk_out (clk_out),
        .locked  (locked)
    );

    always #5 refclk = ~refclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Model: phase = base + n*incr since the last rate change; carries and
    // MSB follow from integer division, lock from edges since last write.
    longint         base [NCH];
    longint         nst  [NCH];
    longint         incr_m [NCH];
    logic [NCH-1:0] ce_m, clk_m;
    int             since;
    int             cnt_ce [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            base[c] = 0; nst[c] = 0; incr_m[c] = longint'(DEF[c]);
        end
        ce_m = '0; clk_m = '0; since = 0;
    endtask

    task automatic model_edge();
        bit     wv, wc;
        longint prev, cur;
        wv = wr_en && (int'(wr_ch) < NCH);
        for (int c = 0; c < NCH; c++) begin
            wc = wv && (int'(wr_ch) == c);
            if (wc && wr_clr) begin
                base[c] = 0; nst[c] = 0; ce_m[c] = 1'b0; clk_m[c] = 1'b0;
            end else begin
                if (ch_en[c]) begin
                    prev = base[c] + nst[c] * incr_m[c];
                    nst[c]++;
                    cur = base[c] + nst[c] * incr_m[c];
                    ce_m[c]  = (cur / M) != (prev / M);
                    clk_m[c] = (cur % M) >= (M / 2);
                end else begin
                    ce_m[c] = 1'b0;
                end
                if (wc) begin
                    base[c] = (base[c] + nst[c] * incr_m[c]) % M;
                    nst[c]  = 0;
                end
            end
            if (wc) incr_m[c] = longint'(wr_incr);
        end
        if (wv) since = 0;
        else if (since < 1000000) since++;
    endtask

    task automatic step(input logic [NCH-1:0] en, input logic we, input logic [2:0] ch,
                        input logic [W-1:0] inc, input logic clr);
        ch_en = en; wr_en = we; wr_ch = ch; wr_incr = inc; wr_clr = clr;
        @(posedge refclk);
        model_edge();
        #1;
        chk("ce_out", 32'(ce_out), 32'(ce_m));
        chk("clk_out", 32'(clk_out), 32'(clk_m));
        chk("locked", 32'(locked), 32'(since >= LC));
        for (int c = 0; c < NCH; c++) cnt_ce[c] += int'(ce_out[c]);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 3'd0, '0, 1'b0);
    endtask

    task automatic clr_cnt();
        for (int c = 0; c < NCH; c++) cnt_ce[c] = 0;
    endtask

    initial begin
        int first_ce;
        model_reset();
        clr_cnt();
        // Write presented during reset must be discarded.
        wr_en = 1'b1; wr_ch = 3'd0; wr_incr = 8'd200; wr_clr = 1'b1;
        #23;
        chk("rst_ce", 32'(ce_out), 0);
        chk("rst_clk", 32'(clk_out), 0);
        chk("rst_locked", 32'(locked), 0);
        wr_en = 1'b0; wr_clr = 1'b0;
        rst = 1'b0;

        first_ce = -1;
        for (int k = 1; k <= 16; k++) begin
            step(2'b01, 1'b0, 3'd0, '0, 1'b0);
            if (first_ce < 0 && ce_out[0]) first_ce = k;
        end
        chk("first_ce_edge", 32'(first_ce), 4);
        chk("ce_cnt_16", 32'(cnt_ce[0]), 4);
        chk("lock_rise", 32'(locked), 1);

        idle(10, 2'b01);
        step(2'b01, 1'b1, 3'd7, 8'd99, 1'b1);
        chk("bad_ch_keeps_lock", 32'(locked), 1);

        step(2'b01, 1'b1, 3'd1, 8'd255, 1'b1);
        chk("wr_drops_lock", 32'(locked), 0);
        clr_cnt();
        idle(256, 2'b11);
        chk("incr255_pulses", 32'(cnt_ce[1]), 255);

        step(2'b11, 1'b1, 3'd1, 8'd0, 1'b1);
        idle(15, 2'b11);
        step(2'b11, 1'b1, 3'd0, 8'd64, 1'b0);
        chk("tc_write_wins", 32'(locked), 0);
        idle(15, 2'b11);
        chk("relock_pending", 32'(locked), 0);
        idle(1, 2'b11);
        chk("relock", 32'(locked), 1);

        clr_cnt();
        idle(1000, 2'b11);
        chk("incr0_pulses", 32'(cnt_ce[1]), 0);

        clr_cnt();
        idle(5, 2'b10);
        chk("disabled_pulses", 32'(cnt_ce[0]), 0);
        idle(20, 2'b11);

        step(2'b11, 1'b1, 3'd0, 8'd128, 1'b1);
        idle(5, 2'b11);
        rst = 1'b1;
        #1;
        chk("midrst_ce", 32'(ce_out), 0);
        chk("midrst_clk", 32'(clk_out), 0);
        chk("midrst_locked", 32'(locked), 0);
        model_reset();
        @(posedge refclk);
        #1;
        rst = 1'b0;
        idle(20, 2'b11);

        for (int i = 0; i < 600; i++) begin
            step(NCH'($urandom), ($urandom_range(0, 7) == 0), 3'($urandom),
                 W'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent clock-enable channels, 1..8.
REQ-002 Parameter ACC_W, default 32: phase-accumulator and increment width, 8..32.
REQ-003 Parameter LOCK_CYCLES, default 1024: settle interval before `locked` asserts, at least 1.
REQ-004 Parameter DEF_INCR, default {NUM_CH{ACC_W'(0)}}: per-channel increment loaded at reset.
REQ-005 refclk  in  1: single clock; all logic is clocked on its rising edge.
REQ-006 rst  in  1: reset, asynchronous, active-high.
REQ-007 ch_en  in  NUM_CH: per-channel run enable.
REQ-008 wr_en  in  1: single-cycle write strobe for reprogramming an increment.
REQ-009 wr_ch  in  3: target channel index for the write.
REQ-010 wr_incr  in  ACC_W: new increment value.
REQ-011 wr_clr  in  1: when high during a write, the target accumulator is zeroed.
REQ-012 ce_out  out  NUM_CH: registered one-cycle clock-enable pulses.
REQ-013 clk_out  out  NUM_CH: registered accumulator MSB, an approximately square reference.
REQ-014 locked  out  1: all channels are settled at their programmed rates.

Function
REQ-015 Each channel SHALL hold an ACC_W-bit accumulator acc and an ACC_W-bit register incr.
REQ-016 On each edge with ch_en[i]=1: sum = acc + incr computed ACC_W+1 bits wide; acc <= sum[ACC_W-1:0]; ce_out[i] <= sum[ACC_W].
REQ-017 On each edge with ch_en[i]=0: acc holds; ce_out[i] <= 0; clk_out[i] holds.
REQ-018 clk_out[i] <= MSB of the next acc value, giving one register of latency, the same as ce_out.
REQ-019 The mean ce rate SHALL be f_refclk * incr / 2^ACC_W; incr=0 gives no pulses ever; the maximum incr is 2^ACC_W-1 and is wrapped modulo 2^ACC_W with no saturation.
REQ-020 Write: when wr_en=1 and wr_ch<NUM_CH, incr[wr_ch] <= wr_incr on that edge, and the new value is first used on the following edge.
REQ-021 When wr_clr=1 on a write, acc[wr_ch] <= 0 and ce_out[wr_ch] <= 0 on that edge, overriding the normal update.
REQ-022 A write with wr_ch>=NUM_CH SHALL be ignored entirely, with no state change and no effect on lock.
REQ-023 A write and ch_en[i]=0 in the same cycle: the write still takes effect and acc holds unless wr_clr=1.
REQ-024 Lock FSM states: SETTLE and LOCKED.
  - SETTLE: a counter counts up to LOCK_CYCLES-1, then the FSM moves to LOCKED.
  - LOCKED: locked=1.
  - Any valid write in either state forces SETTLE with the counter at 0 on that edge.
REQ-025 A valid write on the same edge the counter reaches terminal count SHALL win: the FSM stays in SETTLE and the counter restarts.
REQ-026 locked=1 only in LOCKED and is registered; it deasserts on the edge following a valid write.

Reset
REQ-027 While rst=1, asynchronously: acc=0, incr=DEF_INCR, ce_out=0, clk_out=0, locked=0, FSM=SETTLE, counter=0.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no pulse completion; after release, behaviour is identical to power-up.
REQ-029 Writes presented while rst=1 SHALL be discarded.

Structure
REQ-030 Package clken_pkg SHALL hold the lock FSM state enum, the MAX_CH=8 constant, and the width of the lock counter, computed as $clog2(LOCK_CYCLES+1).
REQ-031 Sub-module clken_nco_ch SHALL implement one channel (accumulator, increment register, ce/clk registers) and be generated NUM_CH times.
REQ-032 The lock FSM and write decode SHALL live in clken_gen.

Verification
REQ-033 ACC_W=8, DEF_INCR[0]=64, ch_en=1, release reset -> first ce_out[0] pulse after the 4th edge, then exactly one pulse every 4 cycles; clk_out[0] high for 2 cycles and low for 2 cycles.
REQ-034 ACC_W=8, incr=255 -> ce_out high 255 of every 256 cycles; incr=0 -> ce_out never high over 1000 cycles.
REQ-035 ACC_W=32, incr=633359156 at 50 MHz -> pulse count over 10^6 cycles is 147465 ±1 (7.373271 MHz).
REQ-036 LOCK_CYCLES=16: locked rises 16 edges after reset release; a valid write at cycle 10 after lock drops locked next edge, and it re-rises 16 edges later; a write with wr_ch=7 (NUM_CH=2) leaves locked=1.
REQ-037 Valid write on the terminal-count edge -> locked stays 0 and the next lock comes LOCK_CYCLES edges later; ch_en=0 for 5 cycles -> no pulses and the phase resumes unchanged.
REQ-038 Assert rst for 1 cycle mid-run with incr=128 -> all outputs 0 immediately and the pulse train restarts from phase 0.
